// File: rtl/des_key_schedule.sv
// DES subkey generator: streams K1..K16 (encrypt) or K16..K1 (decrypt), one per handshake.
// Reverse order is produced by right-rotating C/D on the fly, so no subkey storage is needed.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic        sk_ready,
  output logic [47:0] subkey,
  output logic        sk_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  // Entry i is the FIPS input bit number (1 = MSB) feeding output bit i+1.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  state_t      state_reg, state_next;
  logic [27:0] c_reg, c_next;
  logic [27:0] d_reg, d_next;
  logic [47:0] subkey_reg, subkey_next;
  logic        sk_valid_reg, sk_valid_next;
  logic [3:0]  round_reg, round_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        decrypt_reg, decrypt_next;

  logic [55:0] pc1_key;
  logic [27:0] src_c, src_d, rot_c, rot_d;
  logic        rot_right;
  logic [1:0]  rot_amt;
  logic [55:0] rot_cd;
  logic [47:0] pc2_out;
  logic [7:0]  unused_parity;

  function automatic logic [27:0] rotate(input logic [27:0] v, input logic right,
                                         input logic [1:0] amt);
    logic [27:0] r;
    r = v;
    case ({right, amt})
      3'b001:  r = {v[26:0], v[27]};
      3'b010:  r = {v[25:0], v[27:26]};
      3'b101:  r = {v[0], v[27:1]};
      3'b110:  r = {v[1:0], v[27:2]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Shift count of FIPS round r (1..16).
  function automatic logic [1:0] shift_of(input logic [4:0] r);
    return (r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      localparam int SRC = 64 - PC1[gi];
      assign pc1_key[55-gi] = key[SRC];
    end
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      localparam int SRC = 56 - PC2[gi];
      assign pc2_out[47-gi] = rot_cd[SRC];
    end
    for (gi = 0; gi < 8; gi++) begin : g_parity
      assign unused_parity[gi] = key[8*gi];
    end
  endgenerate

  // Single rotator shared between the initial load and every advance.
  always_comb begin
    src_c     = c_reg;
    src_d     = d_reg;
    rot_right = decrypt_reg;
    rot_amt   = 2'd0;
    if (state_reg == IDLE) begin
      src_c     = pc1_key[55:28];
      src_d     = pc1_key[27:0];
      rot_right = 1'b0;
      rot_amt   = decrypt ? 2'd0 : 2'd1;
    end else if (decrypt_reg) begin
      rot_amt = shift_of(5'd16 - {1'b0, round_reg});
    end else begin
      rot_amt = shift_of({1'b0, round_reg} + 5'd2);
    end
    rot_c  = rotate(src_c, rot_right, rot_amt);
    rot_d  = rotate(src_d, rot_right, rot_amt);
    rot_cd = {rot_c, rot_d};
  end

  always_comb begin
    state_next    = state_reg;
    c_next        = c_reg;
    d_next        = d_reg;
    subkey_next   = subkey_reg;
    sk_valid_next = sk_valid_reg;
    round_next    = round_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    decrypt_next  = decrypt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = RUN;
          c_next        = rot_c;
          d_next        = rot_d;
          subkey_next   = pc2_out;
          decrypt_next  = decrypt;
          sk_valid_next = 1'b1;
          busy_next     = 1'b1;
          round_next    = 4'd0;
        end
      end
      RUN: begin
        if (sk_valid_reg && sk_ready) begin
          if (round_reg == 4'd15) begin
            // Subkey keeps its last value after the final transfer.
            state_next    = IDLE;
            sk_valid_next = 1'b0;
            busy_next     = 1'b0;
            done_next     = 1'b1;
            round_next    = 4'd0;
          end else begin
            c_next      = rot_c;
            d_next      = rot_d;
            subkey_next = pc2_out;
            round_next  = round_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      c_reg        <= '0;
      d_reg        <= '0;
      subkey_reg   <= '0;
      sk_valid_reg <= 1'b0;
      round_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      decrypt_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      c_reg        <= c_next;
      d_reg        <= d_next;
      subkey_reg   <= subkey_next;
      sk_valid_reg <= sk_valid_next;
      round_reg    <= round_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      decrypt_reg  <= decrypt_next;
    end
  end

  assign subkey   = subkey_reg;
  assign sk_valid = sk_valid_reg;
  assign round    = round_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 subkey table.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n, start, decrypt, sk_ready;
  logic [63:0] key;
  logic [47:0] subkey;
  logic        sk_valid, busy, done;
  logic [3:0]  round;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] GOLD_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PARITY   = 64'h0101010101010101;

  logic [47:0] gold [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key(key),
    .sk_ready(sk_ready), .subkey(subkey), .sk_valid(sk_valid), .round(round),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: golden table, 1: all zeros, 2: all ones
  function automatic logic [47:0] expect_sk(input int mode, input logic dec, input int n);
    if (mode == 1) return 48'h0;
    if (mode == 2) return 48'hFFFFFFFFFFFF;
    return dec ? gold[15-n] : gold[n];
  endfunction

  task automatic start_run(input logic dec, input logic [63:0] k);
    start = 1'b1; decrypt = dec; key = k; sk_ready = 1'b0;
    step();
    start = 1'b0;
    check("start_valid", sk_valid, 1);
    check("start_busy", busy, 1);
    check("start_round", round, 0);
    check("start_done", done, 0);
  endtask

  task automatic drain(input logic dec, input int mode, input int pct, input bit disturb,
                       input bit keep_start, input logic [63:0] k);
    int n = 0;
    int cyc = 0;
    logic [47:0] prev_sk;
    logic [3:0]  prev_rnd;
    logic        xfer;
    while (n < 16 && cyc < 400) begin
      sk_ready = ($urandom_range(99) < pct);
      if (disturb) begin
        start = 1'(($urandom_range(1)));
        key = {$urandom, $urandom};
        decrypt = 1'(($urandom_range(1)));
      end
      xfer = sk_valid && sk_ready;
      prev_sk = subkey;
      prev_rnd = round;
      if (xfer) begin
        check("subkey", subkey, expect_sk(mode, dec, n));
        check("round", round, n);
        $display("xfer dec=%0d round=%0d subkey=%h", dec, round, subkey);
      end
      step();
      cyc++;
      if (disturb) begin
        start = 1'b0; key = k; decrypt = dec;
      end
      if (xfer) n++;
      else begin
        check("stall_subkey", subkey, prev_sk);
        check("stall_round", round, prev_rnd);
      end
      if (n < 16) begin
        check("no_early_done", done, 0);
        check("busy_run", busy, 1);
        check("valid_run", sk_valid, 1);
      end
    end
    sk_ready = 1'b0;
    check("transfers", n, 16);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_valid", sk_valid, 0);
    check("end_round", round, 0);
    check("end_subkey_hold", subkey, expect_sk(mode, dec, 15));
    if (pct == 100) check("done_latency", cyc, 16);
    if (!keep_start) begin
      step();
      check("done_pulse", done, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key = '0; sk_ready = 1'b0;
    step(); step();
    check("rst_subkey", subkey, 0);
    check("rst_valid", sk_valid, 0);
    check("rst_round", round, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    // Unstalled encrypt and decrypt
    start_run(1'b0, GOLD_KEY); drain(1'b0, 0, 100, 1'b0, 1'b0, GOLD_KEY);
    start_run(1'b1, GOLD_KEY); drain(1'b1, 0, 100, 1'b0, 1'b0, GOLD_KEY);

    // Backpressure at 30% ready
    start_run(1'b0, GOLD_KEY); drain(1'b0, 0, 30, 1'b0, 1'b0, GOLD_KEY);
    start_run(1'b1, GOLD_KEY); drain(1'b1, 0, 30, 1'b0, 1'b0, GOLD_KEY);

    // Parity bits ignored; start/key/decrypt churn while busy ignored
    start_run(1'b0, GOLD_KEY ^ PARITY); drain(1'b0, 0, 100, 1'b0, 1'b0, GOLD_KEY ^ PARITY);
    start_run(1'b0, GOLD_KEY); drain(1'b0, 0, 60, 1'b1, 1'b0, GOLD_KEY);
    start_run(1'b1, GOLD_KEY); drain(1'b1, 0, 60, 1'b1, 1'b0, GOLD_KEY);

    // Reset during round 7
    start_run(1'b0, GOLD_KEY);
    sk_ready = 1'b1;
    repeat (7) step();
    check("pre_reset_round", round, 7);
    check("pre_reset_subkey", subkey, gold[7]);
    rst_n = 1'b0; sk_ready = 1'b0;
    step();
    check("mid_rst_valid", sk_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_round", round, 0);
    check("mid_rst_subkey", subkey, 0);
    check("mid_rst_done", done, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_done", done, 0);
    check("post_rst_valid", sk_valid, 0);
    start_run(1'b0, GOLD_KEY); drain(1'b0, 0, 100, 1'b0, 1'b0, GOLD_KEY);

    // Back-to-back with start held high: zero key, encrypt then decrypt
    start = 1'b1; decrypt = 1'b0; key = '0; sk_ready = 1'b0;
    step();
    check("b2b_valid", sk_valid, 1);
    drain(1'b0, 1, 100, 1'b0, 1'b1, 64'h0);
    decrypt = 1'b1;
    step();
    check("b2b_restart_valid", sk_valid, 1);
    check("b2b_restart_busy", busy, 1);
    check("b2b_restart_done", done, 0);
    check("b2b_restart_round", round, 0);
    start = 1'b0;
    drain(1'b1, 1, 100, 1'b0, 1'b0, 64'h0);

    // All-ones key
    start_run(1'b0, 64'hFFFFFFFFFFFFFFFF); drain(1'b0, 2, 100, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF);
    start_run(1'b1, 64'hFFFFFFFFFFFFFFFF); drain(1'b1, 2, 100, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
